irq_request_resolver_8259a: RTL and testbench

IRQ_REQUEST_RESOLVER_8259A -- requirements
Module: irq_request_resolver_8259a

---
 rtl/irq_request_resolver_8259a.sv | 161 ++++++++++++++++
 tb/tb_irq_request_resolver_8259a.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/irq_request_resolver_8259a.sv
// ---------------------------------------------------------------------------
// irq_request_resolver_8259a
//
// Request side of an 8259A-style interrupt controller. It captures the eight
// IR lines into the interrupt request register (IRR) in either edge- or
// level-triggered mode. It masks the captured requests and resolves the single
// highest-priority request that may interrupt the current in-service level.
//
// Ports
//   clock                          : single clock, rising edge active
//   reset                          : synchronous, active-high reset
//   level_or_edge_triggered_config : 1 = level-triggered, 0 = edge-triggered
//   interrupt_request_pin[7:0]     : IR0..IR7, already synchronous to clock
//   interrupt_mask[7:0]            : IMR, 1 = line masked
//   special_mask_mode              : 1 = special mask mode active
//   priority_rotate[2:0]           : lowest-priority level (7 -> IR0 highest)
//   freeze                         : high during INTA, holds IRR sets and vector
//   clear_interrupt_request[7:0]   : one-hot IRR clear on acknowledge
//   in_service_register[7:0]       : current ISR
//   highest_level_in_service[7:0]  : one-hot highest-priority ISR bit, or 0
//   interrupt_request_register[7:0]: IRR (registered)
//   interrupt[7:0]                 : one-hot resolved request (registered)
//   interrupt_to_cpu               : INT, OR of interrupt
// ---------------------------------------------------------------------------
module irq_request_resolver_8259a (
  input  logic       clock,
  input  logic       reset,
  input  logic       level_or_edge_triggered_config,
  input  logic [7:0] interrupt_request_pin,
  input  logic [7:0] interrupt_mask,
  input  logic       special_mask_mode,
  input  logic [2:0] priority_rotate,
  input  logic       freeze,
  input  logic [7:0] clear_interrupt_request,
  input  logic [7:0] in_service_register,
  input  logic [7:0] highest_level_in_service,
  output logic [7:0] interrupt_request_register,
  output logic [7:0] interrupt,
  output logic       interrupt_to_cpu
);

  // Re-order a vector into priority order: bit 0 is the highest-priority
  // line, IR(rot+1), and bit 7 is the lowest, IR(rot). The 3-bit index sum
  // gives the mod-8 wrap.
  function automatic logic [7:0] to_priority(input logic [7:0] vec,
                                             input logic [2:0] rot);
    logic [7:0] res;
    logic [2:0] idx;
    res = 8'h00;
    for (int j = 0; j < 8; j++) begin
      idx    = rot + 3'd1 + j[2:0];
      res[j] = vec[idx];
    end
    return res;
  endfunction

  // Inverse of to_priority: map a priority-ordered vector back to IR order.
  function automatic logic [7:0] from_priority(input logic [7:0] vec,
                                               input logic [2:0] rot);
    logic [7:0] res;
    logic [2:0] idx;
    res = 8'h00;
    for (int j = 0; j < 8; j++) begin
      idx      = rot + 3'd1 + j[2:0];
      res[idx] = vec[j];
    end
    return res;
  endfunction

  // In priority order, a level qualifies only if it is strictly above the
  // in-service level. The in-service level and everything below it are
  // blocked. An all-zero input blocks nothing.
  function automatic logic [7:0] above_in_service(input logic [7:0] hl_prio);
    logic [7:0] res;
    logic       seen;
    res  = 8'h00;
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      seen   = seen | hl_prio[j];
      res[j] = ~seen;
    end
    return res;
  endfunction

  // Keep only the lowest set bit, which is the highest priority in priority
  // order.
  function automatic logic [7:0] first_set(input logic [7:0] vec);
    logic [7:0] res;
    logic       found;
    res   = 8'h00;
    found = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (vec[j] && !found) begin
        res[j] = 1'b1;
        found  = 1'b1;
      end else begin
        res[j] = 1'b0;
      end
    end
    return res;
  endfunction

  logic [7:0] prev_pin_r;
  logic [7:0] irr_r;
  logic [7:0] interrupt_r;
  logic [7:0] irr_next_s;
  logic [7:0] candidate_s;
  logic [7:0] qualifier_prio_s;
  logic [7:0] resolved_s;

  // Next IRR value. A clear always wins, and freeze blocks new sets.
  always_comb begin
    irr_next_s = irr_r;
    if (freeze) begin
      irr_next_s = irr_r & ~clear_interrupt_request;
    end else if (level_or_edge_triggered_config) begin
      irr_next_s = interrupt_request_pin & ~clear_interrupt_request;
    end else begin
      irr_next_s = (irr_r | (interrupt_request_pin & ~prev_pin_r))
                   & ~clear_interrupt_request;
    end
  end

  // Resolve the highest-priority unmasked request allowed by the ISR state.
  always_comb begin
    candidate_s      = irr_r & ~interrupt_mask;
    qualifier_prio_s = 8'h00;
    if (special_mask_mode) begin
      // In SMM, only the in-service lines themselves are excluded.
      qualifier_prio_s = to_priority(candidate_s & ~in_service_register,
                                     priority_rotate);
    end else begin
      qualifier_prio_s = to_priority(candidate_s, priority_rotate)
                         & above_in_service(to_priority(highest_level_in_service,
                                                        priority_rotate));
    end
    resolved_s = from_priority(first_set(qualifier_prio_s), priority_rotate);
  end

  // State registers: previous pins, IRR and the resolved vector.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_pin_r  <= 8'h00;
      irr_r       <= 8'h00;
      interrupt_r <= 8'h00;
    end else begin
      prev_pin_r <= interrupt_request_pin;
      irr_r      <= irr_next_s;
      if (freeze) begin
        interrupt_r <= interrupt_r;
      end else begin
        interrupt_r <= resolved_s;
      end
    end
  end

  assign interrupt_request_register = irr_r;
  assign interrupt                  = interrupt_r;
  assign interrupt_to_cpu           = |interrupt_r;

endmodule

// File: tb/tb_irq_request_resolver_8259a.sv
module tb_irq_request_resolver_8259a;

  logic       clock = 1'b0;
  logic       reset;
  logic       level_or_edge_triggered_config;
  logic [7:0] interrupt_request_pin;
  logic [7:0] interrupt_mask;
  logic       special_mask_mode;
  logic [2:0] priority_rotate;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [7:0] interrupt_request_register;
  logic [7:0] interrupt;
  logic       interrupt_to_cpu;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] irr;
    logic [7:0] intr;
    logic       cpu;
  } exp_t;

  exp_t sb[$];

  irq_request_resolver_8259a dut (
    .clock                          (clock),
    .reset                          (reset),
    .level_or_edge_triggered_config (level_or_edge_triggered_config),
    .interrupt_request_pin          (interrupt_request_pin),
    .interrupt_mask                 (interrupt_mask),
    .special_mask_mode              (special_mask_mode),
    .priority_rotate                (priority_rotate),
    .freeze                         (freeze),
    .clear_interrupt_request        (clear_interrupt_request),
    .in_service_register            (in_service_register),
    .highest_level_in_service       (highest_level_in_service),
    .interrupt_request_register     (interrupt_request_register),
    .interrupt                      (interrupt),
    .interrupt_to_cpu               (interrupt_to_cpu)
  );

  always #5 clock = ~clock;

  // Push an expectation, advance one clock, then pop and compare #1 after the edge.
  task automatic step(input string tag, input logic [7:0] irr,
                      input logic [7:0] intr, input logic cpu);
    exp_t e;
    e.tag = tag; e.irr = irr; e.intr = intr; e.cpu = cpu;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty: got=0 entries required=1", tag);
    end else begin
      e = sb.pop_front();
      total++;
      assert (interrupt_request_register === e.irr) else begin
        bad++;
        $error("FAIL %s irr got=%h exp=%h", e.tag, interrupt_request_register, e.irr);
      end
      total++;
      assert (interrupt === e.intr) else begin
        bad++;
        $error("FAIL %s interrupt got=%h exp=%h", e.tag, interrupt, e.intr);
      end
      total++;
      assert (interrupt_to_cpu === e.cpu) else begin
        bad++;
        $error("FAIL %s int_to_cpu got=%b exp=%b", e.tag, interrupt_to_cpu, e.cpu);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; level_or_edge_triggered_config = 1'b0;
    interrupt_request_pin = 8'h00; interrupt_mask = 8'h00;
    special_mask_mode = 1'b0; priority_rotate = 3'd7; freeze = 1'b0;
    clear_interrupt_request = 8'h00; in_service_register = 8'h00;
    highest_level_in_service = 8'h00;
    #2;
    step("reset", 8'h00, 8'h00, 1'b0);

    // Edge mode basic capture and hold.
    reset = 1'b0;
    step("idle", 8'h00, 8'h00, 1'b0);
    interrupt_request_pin = 8'h24;
    step("edge_set", 8'h24, 8'h00, 1'b0);
    step("edge_resolve", 8'h24, 8'h04, 1'b1);
    interrupt_request_pin = 8'h00;
    step("edge_hold", 8'h24, 8'h04, 1'b1);
    clear_interrupt_request = 8'h24;
    step("edge_clear", 8'h00, 8'h04, 1'b1);
    clear_interrupt_request = 8'h00;
    step("edge_empty", 8'h00, 8'h00, 1'b0);

    // Level mode follows the pin.
    level_or_edge_triggered_config = 1'b1;
    interrupt_request_pin = 8'h08;
    step("lvl_1", 8'h08, 8'h00, 1'b0);
    step("lvl_2", 8'h08, 8'h08, 1'b1);
    step("lvl_3", 8'h08, 8'h08, 1'b1);
    interrupt_request_pin = 8'h00;
    step("lvl_fall", 8'h00, 8'h08, 1'b1);
    step("lvl_gone", 8'h00, 8'h00, 1'b0);

    // Rotation and masking.
    interrupt_request_pin = 8'h81; priority_rotate = 3'd0;
    step("rot_load", 8'h81, 8'h00, 1'b0);
    step("rot0", 8'h81, 8'h80, 1'b1);
    priority_rotate = 3'd7;
    step("rot7", 8'h81, 8'h01, 1'b1);
    priority_rotate = 3'd6;
    step("rot6", 8'h81, 8'h80, 1'b1);
    interrupt_mask = 8'h80;
    step("mask7", 8'h81, 8'h01, 1'b1);
    interrupt_mask = 8'h81;
    step("mask_all", 8'h81, 8'h00, 1'b0);
    interrupt_mask = 8'h00;

    // Priority blocking by ISR, and special mask mode.
    priority_rotate = 3'd7; interrupt_request_pin = 8'h0A;
    highest_level_in_service = 8'h04; in_service_register = 8'h04;
    step("blk_load", 8'h0A, 8'h01, 1'b1);
    step("blk_norm", 8'h0A, 8'h02, 1'b1);
    special_mask_mode = 1'b1;
    step("blk_smm", 8'h0A, 8'h02, 1'b1);
    interrupt_request_pin = 8'h0C;
    step("smm_load", 8'h0C, 8'h02, 1'b1);
    step("smm_0c", 8'h0C, 8'h08, 1'b1);
    special_mask_mode = 1'b0;
    step("norm_0c_blocked", 8'h0C, 8'h00, 1'b0);
    highest_level_in_service = 8'h00; in_service_register = 8'h00;
    step("norm_0c_free", 8'h0C, 8'h04, 1'b1);

    // Freeze and clear.
    level_or_edge_triggered_config = 1'b0; interrupt_request_pin = 8'h00;
    clear_interrupt_request = 8'hFF;
    step("clr_all", 8'h00, 8'h04, 1'b1);
    clear_interrupt_request = 8'h00;
    step("clr_idle", 8'h00, 8'h00, 1'b0);
    interrupt_request_pin = 8'h10;
    step("ir4_set", 8'h10, 8'h00, 1'b0);
    step("ir4_resolve", 8'h10, 8'h10, 1'b1);
    freeze = 1'b1; interrupt_request_pin = 8'h11;
    step("frz_no_set", 8'h10, 8'h10, 1'b1);
    interrupt_request_pin = 8'h01;
    step("frz_hold", 8'h10, 8'h10, 1'b1);
    interrupt_request_pin = 8'h11; clear_interrupt_request = 8'h10;
    step("frz_clear", 8'h00, 8'h10, 1'b1);
    freeze = 1'b0; clear_interrupt_request = 8'h00; interrupt_request_pin = 8'h01;
    step("unfrz", 8'h00, 8'h00, 1'b0);
    interrupt_request_pin = 8'h11; clear_interrupt_request = 8'h10;
    step("clear_wins", 8'h00, 8'h00, 1'b0);
    clear_interrupt_request = 8'h00;

    // Reset during acknowledge.
    level_or_edge_triggered_config = 1'b1; interrupt_request_pin = 8'hFF;
    step("ff_load", 8'hFF, 8'h00, 1'b0);
    step("ff_resolve", 8'hFF, 8'h01, 1'b1);
    freeze = 1'b1; reset = 1'b1;
    step("rst_frozen", 8'h00, 8'h00, 1'b0);

    // Pin held high through reset is seen as an edge once reset drops.
    level_or_edge_triggered_config = 1'b0; freeze = 1'b0;
    step("rst_hold", 8'h00, 8'h00, 1'b0);
    reset = 1'b0;
    step("post_rst_edge", 8'hFF, 8'h00, 1'b0);
    step("post_rst_int", 8'hFF, 8'h01, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
